multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle FSM sequencer for the accumulator CPU datapath: PC, IR, memory-data register (MDR), accumulator (ACC), 3-bit ALU, single shared memory port.
- Steps each instruction through fetch, decode, memory and execute states.
- Drives all datapath load/select strobes, the memory read/write handshake and `alu_cont`.
- Replaces the one-shot decode-per-clock controller so that instruction and data accesses share one memory.

Parameters:
- OPW, 4, opcode width (IR[15:12]).
- ALUW, 3, ALU control width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  external pause request, sampled in FETCH only.
- opr  in  OPW  opcode field from IR.
- zero  in  1  ACC==0 flag from datapath.
- mem_ack  in  1  memory access complete (used only with WAIT_STATE_EN).
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe (ACC -> mem[IR addr]).
- adr_sel  out  1  address mux: 0 = PC, 1 = IR[11:0].
- ir_ld  out  1  load IR from memory data.
- mdr_ld  out  1  load MDR from memory data.
- pc_inc  out  1  PC <= PC+1.
- pc_ld  out  1  PC <= IR[11:0].
- acc_ld  out  1  ACC <= ALU result.
- alu_src  out  1  ALU B operand: 0 = MDR, 1 = zero-extended IR[11:0].
- alu_cont  out  ALUW  100 ADD, 011 SUB, 000 AND, 001 OR, 010 PASS_B.
- halted  out  1  high while in HALTED.
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode.

Behaviour:
- Registers: clk is the only clock.
- Reset: rst_n low forces state = FETCH immediately, asynchronously, including mid-instruction. Every output except alu_cont is a registered-state decode, so all are 0 while rst_n is low.
- alu_cont: combinational from opr in every state. It reads 000 when opr holds no ALU instruction.
- Opcodes:
  - 0000 ADD m; 0001 SUB m; 0010 AND m; 0011 OR m; 0100 LDA m (PASS_B).
  - 0101 STA m; 0110 JMP a; 0111 NOP.
  - 1000 SUBI; 1001 ANDI; 1010 ORI (immediate).
  - 1011 JZ a; 1111 HLT.
  - All others are illegal and execute as NOP.
- States and transitions:
  - FETCH:
    - halt=1: hold FETCH with all strobes 0 (paused).
    - Otherwise: mem_rd=1, adr_sel=0. On completion: ir_ld=1, pc_inc=1 -> DECODE.
  - DECODE (no memory strobes):
    - ALU-mem ops and LDA -> MEMRD.
    - Immediate ops -> EXEC.
    - STA -> MEMWR.
    - JMP: pc_ld=1 -> FETCH.
    - JZ: pc_ld = zero -> FETCH.
    - NOP/illegal -> FETCH (illegal=1 for illegal opcodes).
    - HLT -> HALTED.
  - MEMRD: mem_rd=1, adr_sel=1. On completion: mdr_ld=1 -> EXEC.
  - EXEC: acc_ld=1. alu_src=1 for opcodes 1000-1010, otherwise 0 -> FETCH.
  - MEMWR: mem_wr=1, adr_sel=1. On completion -> FETCH.
  - HALTED: halted=1, all strobes 0. Exit only via rst_n; halt input ignored.
- Access completion: each memory access completes in its first cycle unless WAIT_STATE_EN is defined.
- Cycle counts with no wait states (FETCH entry to next FETCH entry):
  - ALU-mem/LDA: 4.
  - Immediate: 3.
  - STA: 3.
  - JMP/JZ/NOP/illegal: 2.
- Strobe exclusivity: ir_ld, pc_inc, mdr_ld, acc_ld, pc_ld are single-cycle pulses. mem_rd and mem_wr are never high together.
- halt priority: halt is sampled only in FETCH; an instruction already past FETCH always completes. halt rising during a wait-state FETCH takes effect only after that access completes.

Optional Feature:
- Macro: WAIT_STATE_EN.
- Defined: FETCH, MEMRD and MEMWR hold their state and keep mem_rd/mem_wr/adr_sel asserted until mem_ack=1. ir_ld/pc_inc/mdr_ld pulse only in the mem_ack cycle. mem_ack outside these states is ignored.
- Not defined: mem_ack is unused and every access completes in one cycle.

Test Plan:
- Reset mid-MEMRD of ADD: rst_n low -> all strobes 0 at once. After release, first cycle is FETCH with mem_rd=1, adr_sel=0.
- ADD (IR=0x0005), no wait states:
  - cycle 0: mem_rd, ir_ld, pc_inc.
  - cycle 1: none.
  - cycle 2: mem_rd, adr_sel, mdr_ld.
  - cycle 3: acc_ld, alu_cont=100, alu_src=0.
- ORI (0xA00F): 3 cycles. EXEC has acc_ld=1, alu_src=1, alu_cont=001. mem_rd never asserted with adr_sel=1.
- JZ with zero=1, then zero=0: DECODE shows pc_ld=1, then pc_ld=0. Each instruction takes 2 cycles.
- Opcode 1100 -> illegal=1 for one DECODE cycle, back to FETCH. HLT -> halted=1, stays across 20 cycles and halt toggles, cleared only by rst_n.
- WAIT_STATE_EN with mem_ack delayed 3 cycles in MEMRD of SUB: mem_rd/adr_sel held 4 cycles, mdr_ld only on the ack cycle. halt=1 in FETCH freezes with mem_rd=0 until halt=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/memory/execute sequencer for the accumulator CPU (one shared memory port).
// Optional macro WAIT_STATE_EN: every memory access is stretched until mem_ack.
module multicycle_controller #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic [OPW-1:0]  opr,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            adr_sel,
  output logic            ir_ld,
  output logic            mdr_ld,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            acc_ld,
  output logic            alu_src,
  output logic [ALUW-1:0] alu_cont,
  output logic            halted,
  output logic            illegal
);

  localparam logic [OPW-1:0] OpAdd  = OPW'(4'h0);
  localparam logic [OPW-1:0] OpSub  = OPW'(4'h1);
  localparam logic [OPW-1:0] OpAnd  = OPW'(4'h2);
  localparam logic [OPW-1:0] OpOr   = OPW'(4'h3);
  localparam logic [OPW-1:0] OpLda  = OPW'(4'h4);
  localparam logic [OPW-1:0] OpSta  = OPW'(4'h5);
  localparam logic [OPW-1:0] OpJmp  = OPW'(4'h6);
  localparam logic [OPW-1:0] OpNop  = OPW'(4'h7);
  localparam logic [OPW-1:0] OpSubi = OPW'(4'h8);
  localparam logic [OPW-1:0] OpAndi = OPW'(4'h9);
  localparam logic [OPW-1:0] OpOri  = OPW'(4'hA);
  localparam logic [OPW-1:0] OpJz   = OPW'(4'hB);
  localparam logic [OPW-1:0] OpHlt  = OPW'(4'hF);

  localparam logic [ALUW-1:0] AluAdd  = ALUW'(3'b100);
  localparam logic [ALUW-1:0] AluSub  = ALUW'(3'b011);
  localparam logic [ALUW-1:0] AluAnd  = ALUW'(3'b000);
  localparam logic [ALUW-1:0] AluOr   = ALUW'(3'b001);
  localparam logic [ALUW-1:0] AluPass = ALUW'(3'b010);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StMemRd,
    StExec,
    StMemWr,
    StHalted
  } state_e;

  state_e state_q, state_d;
  logic   ack;
  logic   fetch_busy_q;

`ifdef WAIT_STATE_EN
  logic fetch_busy_d;

  assign ack = mem_ack;
  // Once a fetch read is on the bus, halt must not abandon it mid-access.
  assign fetch_busy_d = (state_q == StFetch) && mem_rd && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_busy_q <= 1'b0;
    end else begin
      fetch_busy_q <= fetch_busy_d;
    end
  end
`else
  logic unused_mem_ack;

  assign ack            = 1'b1;
  assign fetch_busy_q   = 1'b0;
  assign unused_mem_ack = mem_ack;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    adr_sel = 1'b0;
    ir_ld   = 1'b0;
    mdr_ld  = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    acc_ld  = 1'b0;
    alu_src = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    // Strobes are masked during reset so the datapath sees nothing while rst_n is low.
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          if (!halt || fetch_busy_q) begin
            mem_rd = 1'b1;
            if (ack) begin
              ir_ld   = 1'b1;
              pc_inc  = 1'b1;
              state_d = StDecode;
            end
          end
        end
        StDecode: begin
          unique case (opr)
            OpAdd, OpSub, OpAnd, OpOr, OpLda: state_d = StMemRd;
            OpSubi, OpAndi, OpOri:            state_d = StExec;
            OpSta:                            state_d = StMemWr;
            OpJmp: begin
              pc_ld   = 1'b1;
              state_d = StFetch;
            end
            OpJz: begin
              pc_ld   = zero;
              state_d = StFetch;
            end
            OpNop:                            state_d = StFetch;
            OpHlt:                            state_d = StHalted;
            default: begin
              illegal = 1'b1;
              state_d = StFetch;
            end
          endcase
        end
        StMemRd: begin
          mem_rd  = 1'b1;
          adr_sel = 1'b1;
          if (ack) begin
            mdr_ld  = 1'b1;
            state_d = StExec;
          end
        end
        StExec: begin
          acc_ld  = 1'b1;
          alu_src = (opr == OpSubi) || (opr == OpAndi) || (opr == OpOri);
          state_d = StFetch;
        end
        StMemWr: begin
          mem_wr  = 1'b1;
          adr_sel = 1'b1;
          if (ack) begin
            state_d = StFetch;
          end
        end
        StHalted: begin
          halted = 1'b1;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // ALU function follows the opcode in every state, independent of reset.
  always_comb begin
    alu_cont = AluAnd;
    unique case (opr)
      OpAdd:          alu_cont = AluAdd;
      OpSub, OpSubi:  alu_cont = AluSub;
      OpAnd, OpAndi:  alu_cont = AluAnd;
      OpOr, OpOri:    alu_cont = AluOr;
      OpLda:          alu_cont = AluPass;
      default:        alu_cont = AluAnd;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a random
// instruction stream compared against a per-instruction cycle-sequence model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt = 1'b0;
  logic [3:0] opr = 4'h7;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b1;
  logic       mem_rd, mem_wr, adr_sel, ir_ld, mdr_ld, pc_inc, pc_ld, acc_ld, alu_src;
  logic [2:0] alu_cont;
  logic       halted, illegal;

  int errs = 0;
  int checks = 0;

  // Bit masks of the observed strobe vector.
  localparam logic [10:0] MRd   = 11'h400;
  localparam logic [10:0] MWr   = 11'h200;
  localparam logic [10:0] Adr   = 11'h100;
  localparam logic [10:0] IrLd  = 11'h080;
  localparam logic [10:0] MdrLd = 11'h040;
  localparam logic [10:0] PcInc = 11'h020;
  localparam logic [10:0] PcLd  = 11'h010;
  localparam logic [10:0] AccLd = 11'h008;
  localparam logic [10:0] Src   = 11'h004;
  localparam logic [10:0] Hltd  = 11'h002;
  localparam logic [10:0] Ill   = 11'h001;
  localparam logic [10:0] FetchV = MRd | IrLd | PcInc;

  logic [10:0] obs;
  assign obs = {mem_rd, mem_wr, adr_sel, ir_ld, mdr_ld, pc_inc, pc_ld, acc_ld, alu_src,
                halted, illegal};

  logic [10:0] exp_seq [4];
  int          exp_len;

  always #5 clk = ~clk;

  multicycle_controller #(
    .OPW (4),
    .ALUW(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .halt    (halt),
    .opr     (opr),
    .zero    (zero),
    .mem_ack (mem_ack),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .adr_sel (adr_sel),
    .ir_ld   (ir_ld),
    .mdr_ld  (mdr_ld),
    .pc_inc  (pc_inc),
    .pc_ld   (pc_ld),
    .acc_ld  (acc_ld),
    .alu_src (alu_src),
    .alu_cont(alu_cont),
    .halted  (halted),
    .illegal (illegal)
  );

  // Per-instruction strobe sequence from FETCH entry to the next FETCH entry.
  function automatic void build_expect(input logic [3:0] op, input logic z);
    exp_seq[0] = FetchV;
    exp_seq[1] = '0;
    exp_seq[2] = '0;
    exp_seq[3] = '0;
    exp_len    = 2;
    if (op <= 4'd4) begin
      exp_seq[2] = MRd | Adr | MdrLd;
      exp_seq[3] = AccLd;
      exp_len    = 4;
    end else if (op == 4'd5) begin
      exp_seq[2] = MWr | Adr;
      exp_len    = 3;
    end else if (op == 4'd6) begin
      exp_seq[1] = PcLd;
    end else if (op inside {4'd8, 4'd9, 4'd10}) begin
      exp_seq[2] = AccLd | Src;
      exp_len    = 3;
    end else if (op == 4'd11) begin
      exp_seq[1] = z ? PcLd : '0;
    end else if (op inside {4'd12, 4'd13, 4'd14}) begin
      exp_seq[1] = Ill;
    end
  endfunction

  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    case (op)
      4'd0:        return 3'b100;
      4'd1, 4'd8:  return 3'b011;
      4'd3, 4'd10: return 3'b001;
      4'd4:        return 3'b010;
      default:     return 3'b000;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    halt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errs++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 11'h0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== FetchV) begin
      errs++;
      $display("FAIL reset_release got=%b exp=%b", obs, FetchV);
    end
  endtask

  // Runs one instruction from FETCH; IR (opr) takes the new opcode after the fetch edge.
  task automatic test_instr(input logic [3:0] op, input logic z, input bit rand_halt);
    build_expect(op, z);
    for (int i = 0; i < exp_len; i++) begin
      if (i == 1) begin
        opr  = op;
        zero = z;
      end
      halt = (i > 0 && rand_halt) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_seq[i] || alu_cont !== exp_alu(opr)) begin
        errs++;
        $display("FAIL instr op=%h z=%0d cyc=%0d got=%b alu=%b exp=%b alu=%b",
                 op, z, i, obs, alu_cont, exp_seq[i], exp_alu(opr));
      end
      @(posedge clk);
      #1;
    end
    halt = 1'b0;
  endtask

  task automatic test_reset_mid_memrd;
    @(posedge clk);
    #1;
    opr = 4'h0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== (MRd | Adr | MdrLd)) begin
      errs++;
      $display("FAIL mid_memrd got=%b exp=%b", obs, MRd | Adr | MdrLd);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errs++;
      $display("FAIL async_reset got=%b exp=%b", obs, 11'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== FetchV) begin
      errs++;
      $display("FAIL post_reset_fetch got=%b exp=%b", obs, FetchV);
    end
  endtask

  task automatic test_pause(input int n);
    halt = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        errs++;
        $display("FAIL pause cyc=%0d got=%b exp=%b", i, obs, 11'h0);
      end
      @(posedge clk);
      #1;
    end
    halt = 1'b0;
  endtask

  task automatic test_halted;
    test_instr(4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      halt = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs !== Hltd) begin
        errs++;
        $display("FAIL halted cyc=%0d got=%b exp=%b", i, obs, Hltd);
      end
      @(posedge clk);
      #1;
    end
    halt  = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errs++;
      $display("FAIL halted_reset got=%b exp=%b", obs, 11'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== FetchV) begin
      errs++;
      $display("FAIL halted_release got=%b exp=%b", obs, FetchV);
    end
  endtask

  task automatic test_random(input int n);
    logic [3:0] op;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) test_pause(int'($urandom_range(1, 3)));
      op = 4'($urandom_range(0, 14));
      test_instr(op, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

`ifdef WAIT_STATE_EN
  task automatic test_wait_states;
    logic [10:0] want [10];
    want = '{FetchV, 11'h0, MRd | Adr, MRd | Adr, MRd | Adr, MRd | Adr | MdrLd, AccLd,
             11'h0, MRd, FetchV};
    for (int i = 0; i < 10; i++) begin
      if (i == 1) opr = 4'h1;
      mem_ack = !(i inside {2, 3, 4, 8});
      halt    = (i == 7) || (i == 9);
      @(negedge clk);
      checks++;
      if (obs !== want[i]) begin
        errs++;
        $display("FAIL wait_state cyc=%0d got=%b exp=%b", i, obs, want[i]);
      end
      @(posedge clk);
      #1;
    end
    halt    = 1'b0;
    mem_ack = 1'b1;
    test_instr(4'h7, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_instr(4'h0, 1'b0, 1'b0);
    test_instr(4'hA, 1'b0, 1'b0);
    test_instr(4'hB, 1'b1, 1'b0);
    test_instr(4'hB, 1'b0, 1'b0);
    test_instr(4'hC, 1'b0, 1'b0);
    test_instr(4'h5, 1'b0, 1'b1);
    test_instr(4'h6, 1'b1, 1'b0);
    test_pause(4);
    test_instr(4'h4, 1'b0, 1'b0);
    test_reset_mid_memrd();
    test_instr(4'h1, 1'b0, 1'b0);
    test_halted();
    test_random(200);
`ifdef WAIT_STATE_EN
    test_wait_states();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
